// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants, types and helpers for the UART transmit path.
//   BAUD_DIV_DEF : default clocks per bit (50 MHz system clock, 19200 baud)
//   FRAME_BITS   : bits per 8N1 frame (start + 8 data + stop)
//   tx_state_t   : transmitter FSM states
//   build_frame  : assembles the shift-register image of one 8N1 frame
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BAUD_DIV_DEF = 2604;
    localparam int FRAME_BITS   = 10;

    typedef enum logic {
        IDLE = 1'b0,
        XMIT = 1'b1
    } tx_state_t;

    // Bit 0 goes out first, so the start bit sits at the bottom and the
    // stop bit at the top; the data byte lands LSB-first in between.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO with first-word fall-through read: dout always shows
// the oldest entry while empty is low, and rd retires it.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  synchronous active-low reset; flushes the queue
//   wr     in  1  push din (ignored while full)
//   din    in  8  byte to push
//   rd     in  1  pop the head entry (ignored while empty)
//   dout   out 8  head entry, valid while empty=0
//   empty  out 1  no entries held (registered)
//   full   out 1  DEPTH entries held (registered)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          empty_r;
    logic          full_r;
    logic          wr_en_s;
    logic          rd_en_s;

    // Qualify requests against the registered flags and derive the next count.
    // A write while full is dropped even if a read retires an entry on the
    // same edge, because the decision uses the pre-edge full flag.
    always_comb begin
        wr_en_s = wr & ~full_r;
        rd_en_s = rd & ~empty_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, count and flag registers. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == CNT_ZERO);
            full_r  <= (count_nxt_s == CNT_DEPTH);
        end
    end

    // Storage array; contents need no reset since the flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = empty_r;
    assign full  = full_r;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter. Bytes are queued in a small FIFO and serialised on TX,
// LSB first, each bit held BAUD_DIV clocks. Frames queued behind one another
// go out with no idle gap between the stop bit and the next start bit.
// Ports:
//   clk      in  1  system clock
//   rst_n    in  1  synchronous active-low reset; abandons any frame in flight
//   trmt     in  1  push tx_data into the queue (dropped while full=1)
//   tx_data  in  8  byte to send, sampled only on an accepted trmt
//   full     out 1  queue holds FIFO_DEPTH bytes (registered)
//   busy     out 1  a frame is in progress (registered)
//   tx_done  out 1  high during the last clock of every stop bit (registered)
//   TX       out 1  serial line, idles high (registered)
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       full,
    output logic       busy,
    output logic       tx_done,
    output logic       TX
);

    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [BW-1:0]         BAUD_MAX  = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]         BAUD_ONE  = BW'(1'b1);
    localparam logic [BW-1:0]         BAUD_ZERO = BW'(1'b0);
    localparam logic [3:0]            LAST_BIT  = 4'(FRAME_BITS - 1);
    localparam logic [FRAME_BITS-1:0] LINE_IDLE = {FRAME_BITS{1'b1}};

    tx_state_t             state_r;
    tx_state_t             state_nxt_s;
    logic [BW-1:0]         baud_cnt_r;
    logic [BW-1:0]         baud_cnt_nxt_s;
    logic [3:0]            bit_cnt_r;
    logic [3:0]            bit_cnt_nxt_s;
    logic [FRAME_BITS-1:0] shift_r;
    logic [FRAME_BITS-1:0] shift_nxt_s;
    logic                  tx_r;
    logic                  busy_r;
    logic                  tx_done_r;
    logic                  tx_done_nxt_s;
    logic                  pop_s;
    logic [7:0]            fifo_dout_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (trmt),
        .din   (tx_data),
        .rd    (pop_s),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // Next-state, counter and shifter logic for the transmit FSM.
    always_comb begin
        state_nxt_s    = state_r;
        baud_cnt_nxt_s = baud_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        pop_s          = 1'b0;

        case (state_r)
            IDLE: begin
                baud_cnt_nxt_s = BAUD_ZERO;
                bit_cnt_nxt_s  = 4'd0;
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = build_frame(fifo_dout_s);
                    state_nxt_s = XMIT;
                end else begin
                    shift_nxt_s = LINE_IDLE;
                    state_nxt_s = IDLE;
                end
            end

            XMIT: begin
                if (baud_cnt_r == BAUD_MAX) begin
                    baud_cnt_nxt_s = BAUD_ZERO;
                    if (bit_cnt_r < LAST_BIT) begin
                        // Fill with ones so the line rests high behind the stop bit.
                        shift_nxt_s   = {1'b1, shift_r[FRAME_BITS-1:1]};
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    end else if (!fifo_empty_s) begin
                        // Chain straight into the next frame on the stop-bit edge.
                        pop_s         = 1'b1;
                        shift_nxt_s   = build_frame(fifo_dout_s);
                        bit_cnt_nxt_s = 4'd0;
                    end else begin
                        shift_nxt_s   = LINE_IDLE;
                        bit_cnt_nxt_s = 4'd0;
                        state_nxt_s   = IDLE;
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r + BAUD_ONE;
                end
            end

            default: begin
                baud_cnt_nxt_s = BAUD_ZERO;
                bit_cnt_nxt_s  = 4'd0;
                shift_nxt_s    = LINE_IDLE;
                state_nxt_s    = IDLE;
            end
        endcase

        // tx_done is registered, so it is raised one edge early: it is high
        // exactly while the final clock of the stop bit is on the line.
        tx_done_nxt_s = (state_nxt_s == XMIT) &&
                        (bit_cnt_nxt_s == LAST_BIT) &&
                        (baud_cnt_nxt_s == BAUD_MAX);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 4'd0;
            shift_r    <= LINE_IDLE;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            baud_cnt_r <= baud_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            // TX mirrors the bottom of the shifter without an extra cycle of lag.
            tx_r       <= shift_nxt_s[0];
            busy_r     <= (state_nxt_s == XMIT);
            tx_done_r  <= tx_done_nxt_s;
        end
    end

    assign TX      = tx_r;
    assign busy    = busy_r;
    assign tx_done = tx_done_r;
    assign full    = fifo_full_s;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int B = 16;   // clocks per bit, kept small for a short run
    localparam int D = 4;    // queue depth
    localparam int F = 10 * B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       full;
    logic       busy;
    logic       tx_done;
    logic       TX;

    int checks = 0;
    int passed = 0;

    // Reference model: a queue of accepted bytes plus the elapsed time of the
    // frame on the line; line level follows from elapsed time / B.
    logic [7:0] m_q[$];
    logic [7:0] m_cur = 8'h00;
    int         m_t = 0;
    bit         m_act = 1'b0;

    uart_tx #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .full    (full),
        .busy    (busy),
        .tx_done (tx_done),
        .TX      (TX)
    );

    always #5 clk = ~clk;

    // Expected {TX, busy, tx_done, full} after the most recent edge.
    function automatic logic [3:0] m_out();
        logic tx_b;
        int   idx;
        tx_b = 1'b1;
        if (m_act) begin
            idx = m_t / B;
            if (idx == 0) tx_b = 1'b0;
            else if (idx <= 8) tx_b = m_cur[idx-1];
        end
        return {tx_b, m_act, m_act && (m_t == F - 1), (m_q.size() == D)};
    endfunction

    // Drive one clock of stimulus, advance the model across the edge, and
    // return #1 after the edge with outputs settled.
    task automatic step(input logic rst_v, input logic trmt_v, input logic [7:0] d_v);
        int n;
        bit pop;
        rst_n   = rst_v;
        trmt    = trmt_v;
        tx_data = d_v;
        @(posedge clk);
        n   = m_q.size();
        pop = 1'b0;
        if (!rst_v) begin
            m_q.delete();
            m_act = 1'b0;
            m_t   = 0;
        end else begin
            if (!m_act) begin
                if (n > 0) begin
                    pop   = 1'b1;
                    m_act = 1'b1;
                    m_t   = 0;
                end
            end else begin
                m_t++;
                if (m_t == F) begin
                    m_t = 0;
                    if (n > 0) pop = 1'b1;
                    else m_act = 1'b0;
                end
            end
            if (pop) m_cur = m_q.pop_front();
            if (trmt_v && n < D) m_q.push_back(d_v);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if ({TX, busy, tx_done, full} !== 4'b1000)
            $display("FAIL reset_state got=%b exp=1000", {TX, busy, tx_done, full});
        else passed++;
        step(1'b0, 1'b1, 8'hFF);
        checks++;
        if ({TX, busy, tx_done, full} !== 4'b1000)
            $display("FAIL reset_ignores_trmt got=%b exp=1000", {TX, busy, tx_done, full});
        else passed++;
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if ({TX, busy, tx_done, full} !== 4'b1000)
            $display("FAIL reset_release_idle got=%b exp=1000", {TX, busy, tx_done, full});
        else passed++;
    endtask

    task automatic test_single_a5();
        int done_cnt = 0;
        int done_at = -1;
        step(1'b1, 1'b1, 8'hA5);
        checks++;
        if ({TX, busy, tx_done, full} !== m_out())
            $display("FAIL a5_write_edge got=%b exp=%b", {TX, busy, tx_done, full}, m_out());
        else passed++;
        for (int c = 0; c < F + 2; c++) begin
            step(1'b1, 1'b0, 8'h00);
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            checks++;
            if ({TX, busy, tx_done, full} !== m_out())
                $display("FAIL a5_frame c=%0d got=%b exp=%b", c, {TX, busy, tx_done, full}, m_out());
            else passed++;
        end
        checks++;
        if (done_cnt != 1 || done_at != F - 1)
            $display("FAIL a5_tx_done got=%0d@%0d exp=1@%0d", done_cnt, done_at, F - 1);
        else passed++;
    endtask

    task automatic test_fill_drop();
        logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, bytes[i]);
            checks++;
            if ({TX, busy, tx_done, full} !== m_out())
                $display("FAIL fill_push i=%0d got=%b exp=%b", i, {TX, busy, tx_done, full}, m_out());
            else passed++;
            if (i == 4) begin
                checks++;
                if (full !== 1'b1)
                    $display("FAIL fill_full_set got=%b exp=1", full);
                else passed++;
            end
        end
        for (int c = 0; c < 5 * F + 4; c++) begin
            step(1'b1, 1'b0, 8'h00);
            if (tx_done === 1'b1) done_cnt++;
            checks++;
            if ({TX, busy, tx_done, full} !== m_out())
                $display("FAIL fill_frames c=%0d got=%b exp=%b", c, {TX, busy, tx_done, full}, m_out());
            else passed++;
        end
        checks++;
        if (done_cnt != 5)
            $display("FAIL fill_frame_count got=%0d exp=5", done_cnt);
        else passed++;
    endtask

    task automatic test_push_at_done();
        int busy_cycles = 0;
        step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        for (int c = 0; c < F + 4 && !m_out()[1]; c++) begin
            step(1'b1, 1'b0, 8'h00);
            checks++;
            if ({TX, busy, tx_done, full} !== m_out())
                $display("FAIL pad_first c=%0d got=%b exp=%b", c, {TX, busy, tx_done, full}, m_out());
            else passed++;
        end
        checks++;
        if (tx_done !== 1'b1)
            $display("FAIL pad_reach_done got=%b exp=1", tx_done);
        else passed++;
        step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        checks++;
        if ({TX, busy} !== 2'b10 || {TX, busy, tx_done, full} !== m_out())
            $display("FAIL pad_stop_edge got=%b exp=%b", {TX, busy, tx_done, full}, m_out());
        else passed++;
        for (int c = 0; c < F + 4; c++) begin
            step(1'b1, 1'b0, 8'h00);
            if (busy === 1'b1) busy_cycles++;
            checks++;
            if ({TX, busy, tx_done, full} !== m_out())
                $display("FAIL pad_second c=%0d got=%b exp=%b", c, {TX, busy, tx_done, full}, m_out());
            else passed++;
        end
        checks++;
        if (busy_cycles != F)
            $display("FAIL pad_frame_len got=%0d exp=%0d", busy_cycles, F);
        else passed++;
    endtask

    task automatic test_push_on_pop();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        for (int c = 0; c < F + 4 && !m_out()[1]; c++) step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        checks++;
        if (full !== 1'b0 || {TX, busy, tx_done, full} !== m_out())
            $display("FAIL pop_push_edge got=%b exp=%b", {TX, busy, tx_done, full}, m_out());
        else passed++;
        for (int c = 0; c < 5 * F + 4; c++) begin
            step(1'b1, 1'b0, 8'h00);
            checks++;
            if ({TX, busy, tx_done, full} !== m_out())
                $display("FAIL pop_push_drain c=%0d got=%b exp=%b", c, {TX, busy, tx_done, full}, m_out());
            else passed++;
        end
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        for (int c = 0; c < F && !(m_act && m_t == 4 * B + 3); c++) step(1'b1, 1'b0, 8'h00);
        checks++;
        if (busy !== 1'b1)
            $display("FAIL midrst_in_frame got=%b exp=1", busy);
        else passed++;
        step(1'b0, 1'b1, 8'h77);
        checks++;
        if ({TX, busy, tx_done, full} !== 4'b1000)
            $display("FAIL midrst_edge got=%b exp=1000", {TX, busy, tx_done, full});
        else passed++;
        for (int c = 0; c < 20 * B; c++) begin
            step(1'b1, 1'b0, 8'h00);
            if ({TX, busy, tx_done, full} !== 4'b1000) bad++;
        end
        checks++;
        if (bad != 0)
            $display("FAIL midrst_quiet got=%0d_bad_cycles exp=0", bad);
        else passed++;
    endtask

    task automatic test_all_bytes();
        int next = 0;
        int frames = 0;
        logic do_push;
        for (int c = 0; c < 270 * F && (next < 256 || m_act || m_q.size() > 0); c++) begin
            do_push = (next < 256) && (m_q.size() < D);
            step(1'b1, do_push, 8'(next));
            if (do_push) next++;
            if (tx_done === 1'b1) frames++;
            checks++;
            if ({TX, busy, tx_done, full} !== m_out())
                $display("FAIL all_bytes c=%0d got=%b exp=%b", c, {TX, busy, tx_done, full}, m_out());
            else passed++;
        end
        checks++;
        if (frames != 256)
            $display("FAIL all_bytes_count got=%0d exp=256", frames);
        else passed++;
    endtask

    task automatic test_random();
        logic r_rst;
        logic r_trmt;
        for (int c = 0; c < 4000; c++) begin
            r_rst  = ($urandom_range(0, 1999) != 0);
            r_trmt = ($urandom_range(0, 11) == 0);
            step(r_rst, r_trmt, 8'($urandom_range(0, 255)));
            checks++;
            if ({TX, busy, tx_done, full} !== m_out())
                $display("FAIL random c=%0d got=%b exp=%b", c, {TX, busy, tx_done, full}, m_out());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_fill_drop();
        test_push_at_done();
        test_push_on_pop();
        test_reset_midframe();
        test_all_bytes();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
